// File: rtl/bdu_nd.sv
// -----------------------------------------------------------------------------
// bdu_nd -- bit-serial squared-distance unit with early termination
//
// Receives a query and a reference point one bit-plane per beat, MSB first,
// with all D dimensions in each plane. It accumulates the exact squared
// Euclidean distance. After every plane it checks a lower bound on the final
// distance against the kth-nearest threshold, and abandons the point early
// once that bound reaches the threshold.
//
// Parameters
//   B   coordinate width, equal to the number of planes per point
//   D   number of dimensions (1..16)
//   TW  tag width
//   DW  distance / threshold / bound width
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   et_en, threshold    early-termination enable and kth distance, sampled on
//                       the first beat of a point
//   in_valid/in_ready   input beat handshake
//   in_first, in_tag    plane-0 marker and point tag
//   q_plane, r_plane    query / reference bit of each dimension in this plane
//   out_valid/out_ready result handshake
//   out_term            1 = terminated early, 0 = completed
//   out_dist            exact distance, or the bound that caused termination
//   out_ref             reference coordinates, dimension d at [d*B +: B]
//   out_tag             tag of the point
// -----------------------------------------------------------------------------
module bdu_nd #(
    parameter int B  = 32,
    parameter int D  = 3,
    parameter int TW = 8,
    parameter int DW = 2*B + $clog2(D+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            et_en,
    input  logic [DW-1:0]   threshold,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_first,
    input  logic [TW-1:0]   in_tag,
    input  logic [D-1:0]    q_plane,
    input  logic [D-1:0]    r_plane,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_term,
    output logic [DW-1:0]   out_dist,
    output logic [D*B-1:0]  out_ref,
    output logic [TW-1:0]   out_tag
);

    localparam int JW = $clog2(B+1);
    localparam int FW = B + 2;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t          state_q, state_d;
    logic            et_q;
    logic [DW-1:0]   thr_q;
    logic [TW-1:0]   tag_q;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   p_q, p_d;

    logic            out_term_q;
    logic [DW-1:0]   out_dist_q;
    logic [D*B-1:0]  out_ref_q;
    logic [TW-1:0]   out_tag_q;

    logic            accept, load, done_beat, term_hit, clr;
    logic [D*DW-1:0] dp_flat;     // per-dimension increment of P for this beat
    logic [D*FW-1:0] abs_flat;    // |f_d| of the registered prefixes
    logic [D-1:0]    nz_vec;      // f_d != 0
    logic [D*B-1:0]  ref_full;    // reference bits including the current beat
    logic [D*B-1:0]  ref_part;    // received reference bits, left-aligned
    logic [JW-1:0]   rem_planes;  // B - j
    logic [DW-1:0]   sum_abs, nnz, lb_base, lb;

    assign rem_planes = JW'(B) - j_q;

    // -------------------------------------------------------------------------
    // Per-dimension prefix difference and reference shift register.
    // An in_first beat is applied on top of zeroed state, which handles both
    // the IDLE start and a restart in ACC.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < D; gi++) begin : g_dim
        logic signed [FW-1:0] f_q, f_d, fb;
        logic [B-1:0]         r_q, r_d, rb;
        logic [DW-1:0]        fe, dp;
        logic [FW-1:0]        af;

        always_comb begin
            fb  = in_first ? '0 : f_q;
            rb  = in_first ? '0 : r_q;
            fe  = {{(DW-FW){fb[FW-1]}}, fb};
            // f' = 2f + delta and f'^2 = 4f^2 + 4f*delta + delta^2
            case ({q_plane[gi], r_plane[gi]})
                2'b10: begin
                    f_d = (fb <<< 1) + FW'(1);
                    dp  = (fe << 2) + DW'(1);
                end
                2'b01: begin
                    f_d = (fb <<< 1) - FW'(1);
                    dp  = DW'(1) - (fe << 2);
                end
                default: begin
                    f_d = fb <<< 1;
                    dp  = '0;
                end
            endcase
            r_d = {rb[B-2:0], r_plane[gi]};
            af  = f_q[FW-1] ? FW'(-f_q) : FW'(f_q);
        end

        assign dp_flat[gi*DW +: DW]  = dp;
        assign abs_flat[gi*FW +: FW] = af;
        assign nz_vec[gi]            = |f_q;
        assign ref_full[gi*B +: B]   = r_d;
        assign ref_part[gi*B +: B]   = r_q << rem_planes;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                f_q <= '0;
                r_q <= '0;
            end else if (load) begin
                f_q <= f_d;
                r_q <= r_d;
            end else if (clr) begin
                f_q <= '0;
                r_q <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator update and lower bound.
    // LB = sum over nonzero f of (|f|-1)^2, scaled to the full weight. The
    // arithmetic is modular in DW bits; the true results are non-negative and
    // fit, so wrap-around in intermediate terms cancels out.
    // -------------------------------------------------------------------------
    always_comb begin
        p_d     = (in_first ? '0 : p_q) << 2;
        sum_abs = '0;
        nnz     = '0;
        for (int d = 0; d < D; d++) begin
            p_d     = p_d + dp_flat[d*DW +: DW];
            sum_abs = sum_abs + DW'(abs_flat[d*FW +: FW]);
            nnz     = nnz + DW'(nz_vec[d]);
        end
        j_d     = (in_first ? '0 : j_q) + JW'(1);
        lb_base = p_q - (sum_abs << 1) + nnz;
        lb      = lb_base << {rem_planes, 1'b0};
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // In ACC, j is always within 1..B-1: the Bth beat goes straight to OUT.
    assign term_hit = (state_q == S_ACC) && et_q && (j_q != '0) && (lb >= thr_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load) state_d = done_beat ? S_OUT : S_ACC;
            S_ACC: begin
                if (term_hit)       state_d = S_OUT;
                else if (done_beat) state_d = S_OUT;
            end
            S_OUT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = rst_n;
            S_ACC:   in_ready = rst_n && !term_hit;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    // Non-first beats in IDLE are accepted but not processed.
    assign load      = accept && (in_first || (state_q == S_ACC));
    assign done_beat = load && (j_d == JW'(B));
    assign clr       = (state_q == S_OUT) && out_ready;

    // -------------------------------------------------------------------------
    // Point registers and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            et_q       <= 1'b0;
            thr_q      <= '0;
            tag_q      <= '0;
            j_q        <= '0;
            p_q        <= '0;
            out_term_q <= 1'b0;
            out_dist_q <= '0;
            out_ref_q  <= '0;
            out_tag_q  <= '0;
        end else begin
            if (load) begin
                j_q <= j_d;
                p_q <= p_d;
                if (in_first) begin
                    et_q  <= et_en;
                    thr_q <= threshold;
                    tag_q <= in_tag;
                end
            end else if (clr) begin
                j_q <= '0;
                p_q <= '0;
            end

            if (done_beat) begin
                out_term_q <= 1'b0;
                out_dist_q <= p_d;
                out_ref_q  <= ref_full;
                out_tag_q  <= in_first ? in_tag : tag_q;
            end else if (term_hit) begin
                out_term_q <= 1'b1;
                out_dist_q <= lb;
                out_ref_q  <= ref_part;
                out_tag_q  <= tag_q;
            end
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_term  = out_term_q;
    assign out_dist  = out_dist_q;
    assign out_ref   = out_ref_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_bdu_nd.sv
// -----------------------------------------------------------------------------
// tb_bdu_nd -- directed self-checking bench for bdu_nd (B=8, D=3).
// Points are given as packed coordinates, dimension d at [d*8 +: 8].
// -----------------------------------------------------------------------------
module tb_bdu_nd;

    localparam int B  = 8;
    localparam int D  = 3;
    localparam int TW = 8;
    localparam int DW = 18;

    logic           clk;
    logic           rst_n;
    logic           et_en;
    logic [DW-1:0]  threshold;
    logic           in_valid;
    logic           in_ready;
    logic           in_first;
    logic [TW-1:0]  in_tag;
    logic [D-1:0]   q_plane;
    logic [D-1:0]   r_plane;
    logic           out_valid;
    logic           out_ready;
    logic           out_term;
    logic [DW-1:0]  out_dist;
    logic [D*B-1:0] out_ref;
    logic [TW-1:0]  out_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    bdu_nd #(.B(B), .D(D), .TW(TW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .et_en     (et_en),
        .threshold (threshold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_tag    (in_tag),
        .q_plane   (q_plane),
        .r_plane   (r_plane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_term  (out_term),
        .out_dist  (out_dist),
        .out_ref   (out_ref),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Drives planes b0 .. b0+nb-1; called and returning at posedge+1 unless the
    // DUT drops in_ready, in which case it returns at that negedge.
    // After the first beat, threshold/et_en are scrambled to show they are not
    // re-sampled mid-point.
    task automatic stream(input logic [23:0] qv, input logic [23:0] rv,
                          input logic [7:0] tag, input logic [DW-1:0] thr,
                          input logic et, input int b0, input int nb,
                          output int acc);
        acc = 0;
        for (int b = b0; b < b0 + nb; b++) begin
            in_valid  = 1'b1;
            in_first  = (b == 0);
            in_tag    = tag;
            threshold = (b == 0) ? thr : '0;
            et_en     = (b == 0) ? et : 1'b1;
            for (int d = 0; d < D; d++) begin
                q_plane[d] = qv[d*8 + 7 - b];
                r_plane[d] = rv[d*8 + 7 - b];
            end
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk);
            #1;
            acc++;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        tests_run++;
        if ({out_valid, out_term, out_dist, out_ref, out_tag} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b t=%b d=%0d ref=%h tag=%h, required all 0",
                     out_valid, out_term, out_dist, out_ref, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_complete();
        int acc;
        stream(24'h1E140A, 24'h1E100D, 8'hA5, 18'd100, 1'b1, 0, 7, acc);
        tests_run++;
        if (acc !== 7 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL complete_pre: accepted %0d valid %b, required 7 and 0", acc, out_valid);
        end
        stream(24'h1E140A, 24'h1E100D, 8'hA5, 18'd100, 1'b1, 7, 1, acc);
        tests_run++;
        if (out_valid !== 1'b1 || out_term !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL complete_latency: valid %b term %b ready %b, required 1 0 0",
                     out_valid, out_term, in_ready);
        end
        tests_run++;
        if (out_dist !== 18'd25 || out_ref !== 24'h1E100D || out_tag !== 8'hA5) begin
            tests_failed++;
            $display("FAIL complete_result: dist %0d ref %h tag %h, required 25 1e100d a5",
                     out_dist, out_ref, out_tag);
        end
        take_result();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL complete_accept: ready %b valid %b, required 1 0", in_ready, out_valid);
        end
        $display("[TB] complete: dist=%0d tag=%h", out_dist, out_tag);
    endtask

    task automatic test_early_term();
        int acc;
        stream(24'h000000, 24'h0000FF, 8'h3C, 18'd1000, 1'b1, 0, 8, acc);
        tests_run++;
        if (acc !== 2 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL term_eval_cycle: accepted %0d ready %b valid %b, required 2 0 0",
                     acc, in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_term !== 1'b1 || out_dist !== 18'd16384) begin
            tests_failed++;
            $display("FAIL term_result: valid %b term %b dist %0d, required 1 1 16384",
                     out_valid, out_term, out_dist);
        end
        tests_run++;
        if (out_ref !== 24'h0000C0 || out_tag !== 8'h3C) begin
            tests_failed++;
            $display("FAIL term_ref_tag: ref %h tag %h, required 0000c0 3c", out_ref, out_tag);
        end
        take_result();
        $display("[TB] early_term: dist=%0d term=%b", out_dist, out_term);
    endtask

    task automatic test_et_disabled();
        int acc;
        stream(24'h000000, 24'h0000FF, 8'h11, 18'd1000, 1'b0, 0, 8, acc);
        tests_run++;
        if (acc !== 8 || out_valid !== 1'b1 || out_term !== 1'b0 || out_dist !== 18'd65025
            || out_ref !== 24'h0000FF) begin
            tests_failed++;
            $display("FAIL et_disabled: acc %0d valid %b term %b dist %0d ref %h, required 8 1 0 65025 0000ff",
                     acc, out_valid, out_term, out_dist, out_ref);
        end
        take_result();
        $display("[TB] et_disabled: dist=%0d", out_dist);
    endtask

    task automatic test_backpressure();
        int acc;
        stream(24'h050505, 24'h030201, 8'h42, 18'd0, 1'b0, 0, 8, acc);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({out_valid, in_ready, out_term} !== 3'b100 || out_dist !== 18'd29
                || out_ref !== 24'h030201 || out_tag !== 8'h42) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: valid %b ready %b dist %0d ref %h tag %h, required 1 0 29 030201 42",
                         c, out_valid, in_ready, out_dist, out_ref, out_tag);
            end
        end
        take_result();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: ready %b valid %b, required 1 0", in_ready, out_valid);
        end
        $display("[TB] backpressure: dist=%0d", out_dist);
    endtask

    task automatic test_restart();
        int acc;
        stream(24'h030201, 24'h3264C8, 8'h66, 18'd0, 1'b0, 0, 4, acc);
        tests_run++;
        if (acc !== 4 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_abandon: acc %0d valid %b, required 4 0", acc, out_valid);
        end
        stream(24'h640007, 24'h640903, 8'h77, 18'd0, 1'b0, 0, 8, acc);
        tests_run++;
        if (out_valid !== 1'b1 || out_term !== 1'b0 || out_dist !== 18'd97
            || out_ref !== 24'h640903 || out_tag !== 8'h77) begin
            tests_failed++;
            $display("FAIL restart_result: valid %b term %b dist %0d ref %h tag %h, required 1 0 97 640903 77",
                     out_valid, out_term, out_dist, out_ref, out_tag);
        end
        take_result();
        $display("[TB] restart: dist=%0d tag=%h", out_dist, out_tag);
    endtask

    task automatic test_stray();
        int ready_ok = 1;
        in_valid = 1'b1;
        in_first = 1'b0;
        q_plane  = 3'b000;
        r_plane  = 3'b111;
        for (int c = 0; c < B; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) ready_ok = 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (ready_ok != 1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stray_discard: ready_ok %0d valid %b ready %b, required 1 0 1",
                     ready_ok, out_valid, in_ready);
        end
        $display("[TB] stray: %0d non-first beats discarded", B);
    endtask

    task automatic test_thr_bounds();
        int acc;
        stream(24'h1E140A, 24'h1E100D, 8'h0F, 18'd0, 1'b1, 0, 8, acc);
        tests_run++;
        if (acc !== 1) begin
            tests_failed++;
            $display("FAIL thr_zero_beats: accepted %0d, required 1", acc);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_term !== 1'b1 || out_dist !== 18'd0 || out_ref !== 24'h0) begin
            tests_failed++;
            $display("FAIL thr_zero_result: valid %b term %b dist %0d ref %h, required 1 1 0 000000",
                     out_valid, out_term, out_dist, out_ref);
        end
        take_result();
        stream(24'h000000, 24'hFFFFFF, 8'hF0, 18'h3FFFF, 1'b1, 0, 8, acc);
        tests_run++;
        if (acc !== 8 || out_valid !== 1'b1 || out_term !== 1'b0 || out_dist !== 18'd195075) begin
            tests_failed++;
            $display("FAIL thr_max: acc %0d valid %b term %b dist %0d, required 8 1 0 195075",
                     acc, out_valid, out_term, out_dist);
        end
        take_result();
        $display("[TB] thr_bounds: max-threshold dist=%0d", out_dist);
    endtask

    task automatic test_async_reset();
        int acc;
        stream(24'h1E140A, 24'h1E100D, 8'h5A, 18'd0, 1'b0, 0, 4, acc);
        in_valid = 1'b1;
        in_first = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || {out_valid, out_term, out_dist, out_ref, out_tag} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: ready %b valid %b term %b dist %0d ref %h tag %h, required all 0",
                     in_ready, out_valid, out_term, out_dist, out_ref, out_tag);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_release: ready %b valid %b, required 1 0", in_ready, out_valid);
        end
        stream(24'h1E140A, 24'h1E100D, 8'h5B, 18'd0, 1'b0, 0, 8, acc);
        tests_run++;
        if (out_valid !== 1'b1 || out_dist !== 18'd25 || out_tag !== 8'h5B) begin
            tests_failed++;
            $display("FAIL async_fresh_point: valid %b dist %0d tag %h, required 1 25 5b",
                     out_valid, out_dist, out_tag);
        end
        take_result();
        $display("[TB] async_reset: fresh dist=%0d", out_dist);
    endtask

    initial begin
        rst_n     = 1'b0;
        et_en     = 1'b0;
        threshold = '0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_tag    = '0;
        q_plane   = '0;
        r_plane   = '0;
        out_ready = 1'b0;

        test_reset();
        test_complete();
        test_early_term();
        test_et_disabled();
        test_backpressure();
        test_restart();
        test_stray();
        test_thr_bounds();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
